// File: rtl/sram_drv_pkg.sv
// Shared definitions for the SRAM RW-port driver.
// Holds the macro geometry, the derived address/data widths, the
// controller state type, and the per-lane mask expansion helper.
// The geometry constants here are the single source of truth for the
// driver, its response buffer, and the testbench.
package sram_drv_pkg;

    localparam int SETS         = 2048;
    localparam int LANES        = 6;
    localparam int LANE_W       = 31;
    localparam int STARVE_LIMIT = 4;

    localparam int ADDR_W   = $clog2(SETS);
    localparam int WIDTH    = LANES * LANE_W;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } drv_state_e;

    // Turns a LANES-bit lane enable into a WIDTH-bit bit enable.
    function automatic logic [WIDTH-1:0] expand_mask(input logic [LANES-1:0] mask);
        logic [WIDTH-1:0] bits;
        bits = '0;
        for (int l = 0; l < LANES; l++) begin
            bits[l*LANE_W +: LANE_W] = {LANE_W{mask[l]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_rd_resp_buf.sv
// Two-entry FIFO that holds read data returned by the macro until the
// consumer takes it.
// Ports:
//   clock, reset   clock and synchronous active-high reset (empties FIFO)
//   push, din      write din at the tail
//   pop, dout      dout is the head; pop removes it
//   count          entries held (0..2)
//   empty          no entries held
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; the caller's credit scheme guarantees that is the only case.
module sram_rd_resp_buf
    import sram_drv_pkg::*;
#(
    parameter int DATA_W = WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count,
    output logic              empty
);

    logic [DATA_W-1:0] slot [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        empty   = (count == 2'd0);
        full    = (count == 2'd2);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = slot[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clock) begin
        if (do_push) slot[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_rw_port_driver.sv
// Requester-side controller for a single-port lane-masked SRAM macro.
// After reset it sweeps every address writing zero (INIT), then merges a
// write channel and a read channel onto the single RW port (RUN) and
// returns read data through a backpressurable response channel.
// Ports:
//   clock, reset                       clock; synchronous active-high reset
//   w_req_valid/ready/addr/mask/data   write request channel
//   r_req_valid/ready/addr             read request channel
//   r_resp_valid/ready/data            read response channel, request order
//   init_done                          high once the zero sweep finished
//   sram_en/wmode/addr/wmask/wdata     macro RW0 request (same clock)
//   sram_rdata                         macro read data, one cycle after en
module sram_rw_port_driver
    import sram_drv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [LANES-1:0]  w_req_mask,
    input  logic [WIDTH-1:0]  w_req_data,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    input  logic              r_resp_ready,
    output logic [WIDTH-1:0]  r_resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LANES-1:0]  sram_wmask,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata
);

    drv_state_e          state;
    drv_state_e          state_nxt;
    logic [ADDR_W-1:0]   init_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                inflight;

    logic                run;
    logic                starve_hit;
    logic                credit_ok;
    logic                w_grant;
    logic                r_grant;
    logic [1:0]          occupancy;
    logic [1:0]          buf_count;
    logic                buf_empty;
    logic                buf_pop;

    // Arbitration and credit. Each ready looks only at the other channel's
    // valid, so neither ready loops back through its own requester. The two
    // grant terms are mutually exclusive: a write needs !(starve_hit &&
    // r_req_valid) while a read alongside a write needs starve_hit.
    always_comb begin
        run          = (state == RUN);
        starve_hit   = (starve_cnt == STARVE_W'(STARVE_LIMIT));
        occupancy    = {1'b0, inflight} + buf_count;
        r_resp_valid = !buf_empty;
        buf_pop      = r_resp_valid && r_resp_ready;
        // A slot freed by this cycle's pop can be handed out immediately,
        // which is what keeps back-to-back reads at full rate.
        credit_ok    = (occupancy < 2'd2) || buf_pop;
        w_req_ready  = run && !(starve_hit && r_req_valid);
        r_req_ready  = run && credit_ok && (!w_req_valid || starve_hit);
        w_grant      = w_req_valid && w_req_ready;
        r_grant      = r_req_valid && r_req_ready;
        init_done    = run;
    end

    // Next state and macro request.
    always_comb begin
        state_nxt  = state;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        case (state)
            INIT: begin
                // Held off while reset is asserted so the macro sees no
                // traffic until the sweep actually starts.
                sram_en    = !reset;
                sram_wmode = 1'b1;
                sram_addr  = init_cnt;
                sram_wmask = '1;
                if (init_cnt == ADDR_W'(SETS - 1)) state_nxt = RUN;
            end
            RUN: begin
                sram_en = w_grant || r_grant;
                if (w_grant) begin
                    sram_wmode = 1'b1;
                    sram_addr  = w_req_addr;
                    sram_wmask = w_req_mask;
                    sram_wdata = w_req_data;
                end else if (r_grant) begin
                    sram_addr = r_req_addr;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            init_cnt   <= '0;
            starve_cnt <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= r_grant;
            if (state == INIT) init_cnt <= init_cnt + ADDR_W'(1);
            // Counts writes that overtook a waiting read; any break in the
            // read request or a read grant forgives the history.
            if (r_grant || !r_req_valid) begin
                starve_cnt <= '0;
            end else if (w_grant && !starve_hit) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    // Read data is captured the cycle after the grant regardless of what
    // the port is doing now, so a write issued right behind a read to the
    // same address cannot disturb the returned (old) value.
    sram_rd_resp_buf #(
        .DATA_W(WIDTH)
    ) u_resp_buf (
        .clock (clock),
        .reset (reset),
        .push  (inflight),
        .din   (sram_rdata),
        .pop   (buf_pop),
        .dout  (r_resp_data),
        .count (buf_count),
        .empty (buf_empty)
    );

endmodule
